// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl
// Sequences one SHA-256 compression per accepted 512-bit block: loads the
// W scheduler, walks the round index through the K ROM, raises the core's
// init / ready / last_round strobes and supplies the chaining value. The
// final working state of the last block of a message is published as the
// digest, qualified by a one-cycle digest_valid pulse.

module sha256_round_ctrl #(
  parameter int           ROUNDS = 64,
  parameter logic [255:0] IV     = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         blk_ready,
  output logic         sched_load,
  output logic         sched_en,
  output logic [5:0]   round_idx,
  output logic         core_init,
  output logic         core_ready,
  output logic         core_last_round,
  output logic [255:0] h_init,
  input  logic [255:0] core_digest,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Index of the final round; the FSM leaves ROUND on this count, so the
  // 6-bit counter never wraps.
  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  state_t         state_q;
  state_t         state_d;
  logic [5:0]     cnt_q;
  logic           first_q;
  logic           last_q;
  logic [255:0]   chain_q;
  logic           accept;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering in simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and per-state strobes for the scheduler and core.
  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    accept          = 1'b0;
    blk_ready       = 1'b0;
    sched_load      = 1'b0;
    sched_en        = 1'b0;
    core_init       = 1'b0;
    core_ready      = 1'b0;
    core_last_round = 1'b0;
    case (state_q)
      IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          accept     = 1'b1;
          sched_load = 1'b1;
          state_d    = ROUND;
        end
      end
      ROUND: begin
        sched_en   = 1'b1;
        core_init  = (cnt_q == 6'd0);
        // Low only in round 0 so the core re-latches h_init as its
        // feed-forward copy exactly when it starts a new block.
        core_ready = (cnt_q != 6'd0);
        if (cnt_q == LAST_IDX) begin
          core_last_round = 1'b1;
          state_d         = DONE;
        end
      end
      DONE: begin
        core_ready = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Round counter, per-block flags, chaining value and published digest.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= 6'd0;
      first_q      <= 1'b1;
      last_q       <= 1'b0;
      chain_q      <= IV;
      digest       <= '0;
      digest_valid <= 1'b0;
    end else begin
      digest_valid <= 1'b0;
      if (accept) begin
        first_q <= blk_first;
        last_q  <= blk_last;
        cnt_q   <= 6'd0;
      end
      if (core_last_round) begin
        cnt_q <= 6'd0;
      end else if (sched_en) begin
        cnt_q <= cnt_q + 6'd1;
      end
      if (state_q == DONE) begin
        chain_q <= core_digest;
        if (last_q) begin
          digest       <= core_digest;
          digest_valid <= 1'b1;
        end
      end
    end
  end

  // first_q and chain_q only move on accept or in DONE, so h_init is
  // constant for the whole span of rounds of a block.
  assign h_init    = first_q ? IV : chain_q;
  assign round_idx = cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl
// Drives sha256_round_ctrl with a behavioural SHA-256 core and W scheduler
// that obey the controller's strobes, and scores published digests against
// known SHA-256 answers held in a queue.

module tb_sha256_round_ctrl;

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [0:63][31:0] K_TAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Padded message blocks and their reference digests.
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_448_1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_448_2 = {480'h0, 32'h000001c0};

  localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_448   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic         clk = 1'b0;
  logic         reset;
  logic         blk_valid;
  logic         blk_first;
  logic         blk_last;
  logic [511:0] blk_data;
  logic         blk_ready;
  logic         sched_load;
  logic         sched_en;
  logic [5:0]   round_idx;
  logic         core_init;
  logic         core_ready;
  logic         core_last_round;
  logic [255:0] h_init;
  logic [255:0] core_digest;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dv_count = 0;

  typedef struct {
    logic [255:0] dig;
    int           acc;
  } exp_t;
  exp_t sb[$];

  sha256_round_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .blk_valid       (blk_valid),
    .blk_first       (blk_first),
    .blk_last        (blk_last),
    .blk_ready       (blk_ready),
    .sched_load      (sched_load),
    .sched_en        (sched_en),
    .round_idx       (round_idx),
    .core_init       (core_init),
    .core_ready      (core_ready),
    .core_last_round (core_last_round),
    .h_init          (h_init),
    .core_digest     (core_digest),
    .digest          (digest),
    .digest_valid    (digest_valid),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural SHA-256 core + W scheduler ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] next_w(input logic [511:0] win);
    logic [31:0] w1;
    logic [31:0] w14;
    logic [31:0] s0;
    logic [31:0] s1;
    w1  = win[479:448];
    w14 = win[63:32];
    s0  = rotr(w1, 7) ^ rotr(w1, 18) ^ (w1 >> 3);
    s1  = rotr(w14, 17) ^ rotr(w14, 19) ^ (w14 >> 10);
    return win[511:480] + s0 + win[223:192] + s1;
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  function automatic logic [255:0] core_step(input logic init, input logic last, input logic [255:0] hi,
                                             input logic [255:0] st, input logic [255:0] ff,
                                             input logic [31:0] k, input logic [31:0] w);
    logic [255:0] n;
    n = sha_round(init ? hi : st, k, w);
    return last ? add8(n, ff) : n;
  endfunction

  logic [511:0] m_win = '0;
  logic [255:0] m_st  = '0;
  logic [255:0] m_ff  = '0;

  always @(posedge clk) begin
    if (sched_load) m_win <= blk_data;
    else if (sched_en) m_win <= {m_win[479:0], next_w(m_win)};
    if (!core_ready) m_ff <= h_init;
    if (sched_en)
      m_st <= core_step(core_init, core_last_round, h_init, m_st, m_ff, K_TAB[round_idx], m_win[511:480]);
  end

  assign core_digest = m_st;

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (digest_valid === 1'b1) begin
      dv_count++;
      if (sb.size() == 0) begin
        check("dv_unexpected", 256'(digest_valid), 256'd0);
      end else begin
        e = sb.pop_front();
        check("digest", digest, e.dig);
        check("latency", 256'(cyc - e.acc), 256'd66);
      end
    end
  end

  // ---------------- stimulus tasks (entered on a falling edge) ----------------
  task automatic send_block(input logic [511:0] blk, input logic f, input logic l,
                            input logic [255:0] exp, input bit hold, output int acc);
    exp_t e;
    blk_data  = blk;
    blk_first = f;
    blk_last  = l;
    blk_valid = 1'b1;
    for (int n = 0; n < 200 && blk_ready !== 1'b1; n++) @(negedge clk);
    acc = -1;
    if (blk_ready !== 1'b1) begin
      check("accept_timeout", 256'(blk_ready), 256'd1);
      blk_valid = 1'b0;
      return;
    end
    acc = cyc;
    if (l) begin
      e.dig = exp;
      e.acc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    if (!hold) blk_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk);
    check(tag, 256'(sb.size()), 256'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_blk_ready"},  256'(blk_ready),       256'd1);
    check({tag, "_busy"},       256'(busy),            256'd0);
    check({tag, "_sched_load"}, 256'(sched_load),      256'd0);
    check({tag, "_sched_en"},   256'(sched_en),        256'd0);
    check({tag, "_core_init"},  256'(core_init),       256'd0);
    check({tag, "_last_round"}, 256'(core_last_round), 256'd0);
    check({tag, "_core_ready"}, 256'(core_ready),      256'd0);
    check({tag, "_round_idx"},  256'(round_idx),       256'd0);
    check({tag, "_h_init"},     h_init,                IV);
    check({tag, "_digest"},     digest,                256'd0);
    check({tag, "_dv"},         256'(digest_valid),    256'd0);
  endtask

  // Per-cycle strobe walk over one "abc" block, with a stray blk_valid pulse.
  task automatic strobe_block();
    int acc;
    int n_init = 0;
    int n_last = 0;
    int init_at = -1;
    int last_at = -1;
    int strobe_err = 0;
    send_block(BLK_ABC, 1'b1, 1'b1, D_ABC, 1'b0, acc);
    for (int k = 0; k < 64; k++) begin
      if (sched_en !== 1'b1 || round_idx !== 6'(k) || core_ready !== (k != 0) ||
          blk_ready !== 1'b0 || busy !== 1'b1 || sched_load !== 1'b0)
        strobe_err++;
      if (core_init === 1'b1) begin n_init++; init_at = int'(round_idx); end
      if (core_last_round === 1'b1) begin n_last++; last_at = int'(round_idx); end
      if (k == 20) begin
        blk_valid = 1'b1;
        #1;
        check("midround_sched_load", 256'(sched_load), 256'd0);
        check("midround_blk_ready",  256'(blk_ready),  256'd0);
      end
      if (k == 21) blk_valid = 1'b0;
      @(negedge clk);
    end
    check("strobe_err",      256'(strobe_err), 256'd0);
    check("core_init_count", 256'(n_init),     256'd1);
    check("core_init_at",    256'(init_at),    256'd0);
    check("last_round_cnt",  256'(n_last),     256'd1);
    check("last_round_at",   256'(last_at),    256'd63);
    check("done_busy",       256'(busy),       256'd1);
    check("done_sched_en",   256'(sched_en),   256'd0);
    check("done_blk_ready",  256'(blk_ready),  256'd0);
    @(negedge clk);
    check("ready_again",     256'(blk_ready),  256'd1);
    check("idle_core_ready", 256'(core_ready), 256'd0);
  endtask

  initial begin
    int acc1;
    int acc2;
    int dv0;
    reset     = 1'b1;
    blk_valid = 1'b0;
    blk_first = 1'b0;
    blk_last  = 1'b0;
    blk_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);

    // Single "abc" block with per-cycle strobe checks.
    strobe_block();
    drain("drain_abc");

    // Empty message.
    send_block(BLK_EMPTY, 1'b1, 1'b1, D_EMPTY, 1'b0, acc1);
    drain("drain_empty");

    // Two-block 448-bit message; only the second block publishes.
    dv0 = dv_count;
    send_block(BLK_448_1, 1'b1, 1'b0, 256'd0, 1'b0, acc1);
    send_block(BLK_448_2, 1'b0, 1'b1, D_448, 1'b0, acc2);
    drain("drain_448");
    check("dv_count_448", 256'(dv_count - dv0), 256'd1);

    // Back-to-back with blk_valid held high; second message restarts from IV.
    dv0 = dv_count;
    send_block(BLK_ABC,   1'b1, 1'b1, D_ABC,   1'b1, acc1);
    send_block(BLK_EMPTY, 1'b1, 1'b1, D_EMPTY, 1'b0, acc2);
    check("b2b_gap", 256'(acc2 - acc1), 256'd66);
    drain("drain_b2b");
    check("dv_count_b2b", 256'(dv_count - dv0), 256'd2);

    // Reset at round 30 of the first block of the two-block message.
    send_block(BLK_448_1, 1'b1, 1'b0, 256'd0, 1'b0, acc1);
    for (int n = 0; n < 100 && !(sched_en === 1'b1 && round_idx == 6'd30); n++) @(negedge clk);
    check("rst_round30_found", 256'(round_idx), 256'd30);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    dv0 = dv_count;
    repeat (80) @(negedge clk);
    check("no_dv_after_rst", 256'(dv_count - dv0), 256'd0);

    // Non-first block straight after reset chains from the reset value IV.
    send_block(BLK_ABC, 1'b0, 1'b1, D_ABC, 1'b0, acc1);
    drain("drain_post_rst");
    repeat (5) @(negedge clk);
    check("digest_hold", digest, D_ABC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
